// File: rtl/param_ring_counter.sv
// param_ring_counter: WIDTH-bit ring (MODE=0) or Johnson (MODE=1) counter with direction, load, wrap pulse and legal-state flag.
// Define PARAM_RC_SELF_CORRECT_EN to force illegal states back to SEED on the next enabled step.
module param_ring_counter #(
  parameter int WIDTH = 3,
  parameter int MODE  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_valid_state
);
  localparam logic [WIDTH-1:0] SEED = (MODE == 1) ? '0 : WIDTH'(1);
  logic [WIDTH-1:0] r_count, w_shift, w_next;
  logic [WIDTH-2:0] w_trans;
  logic             r_wrap, w_onehot, w_johnson, w_fill_l, w_fill_r, w_wrap_next;
  // Johnson patterns are exactly those with at most one adjacent-bit transition
  always_comb begin
    w_trans       = r_count[WIDTH-1:1] ^ r_count[WIDTH-2:0];
    w_onehot      = (r_count != '0) && ((r_count & (r_count - WIDTH'(1))) == '0);
    w_johnson     = (w_trans & (w_trans - (WIDTH-1)'(1))) == '0;
    o_valid_state = (MODE == 1) ? w_johnson : w_onehot;
    w_fill_l      = (MODE == 1) ? ~r_count[WIDTH-1] : r_count[WIDTH-1];
    w_fill_r      = (MODE == 1) ? ~r_count[0] : r_count[0];
    w_shift       = i_dir ? {w_fill_r, r_count[WIDTH-1:1]} : {r_count[WIDTH-2:0], w_fill_l};
  end
`ifdef PARAM_RC_SELF_CORRECT_EN
  assign w_next      = o_valid_state ? w_shift : SEED;
  assign w_wrap_next = o_valid_state && (w_shift == SEED);
`else
  assign w_next      = w_shift;
  assign w_wrap_next = w_shift == SEED;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= SEED;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_wrap  <= 1'b0;
    end else if (i_enable) begin
      r_count <= w_next;
      r_wrap  <= w_wrap_next;
    end else begin
      r_wrap  <= 1'b0;
    end
  end
  assign o_count = r_count;
  assign o_wrap  = r_wrap;
endmodule

// File: tb/tb_param_ring_counter.sv
// tb_param_ring_counter: scoreboard bench over ring/Johnson instances of widths 4, 2 and 32.
module tb_param_ring_counter;
  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, dir = 1'b0, ld = 1'b0;
  logic [31:0] lv = '0;
  logic [3:0]  c0, c1;
  logic [1:0]  c2, c3;
  logic [31:0] c4, c5;
  logic [5:0]  w, v;
  logic [5:0][31:0] dc;
  always #5 clk = ~clk;

  param_ring_counter #(.WIDTH(4),  .MODE(0)) u_r4  (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv[3:0]), .o_count(c0), .o_wrap(w[0]), .o_valid_state(v[0]));
  param_ring_counter #(.WIDTH(4),  .MODE(1)) u_j4  (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv[3:0]), .o_count(c1), .o_wrap(w[1]), .o_valid_state(v[1]));
  param_ring_counter #(.WIDTH(2),  .MODE(0)) u_r2  (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv[1:0]), .o_count(c2), .o_wrap(w[2]), .o_valid_state(v[2]));
  param_ring_counter #(.WIDTH(2),  .MODE(1)) u_j2  (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv[1:0]), .o_count(c3), .o_wrap(w[3]), .o_valid_state(v[3]));
  param_ring_counter #(.WIDTH(32), .MODE(0)) u_r32 (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv),      .o_count(c4), .o_wrap(w[4]), .o_valid_state(v[4]));
  param_ring_counter #(.WIDTH(32), .MODE(1)) u_j32 (.i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_dir(dir), .i_load(ld), .i_load_val(lv),      .o_count(c5), .o_wrap(w[5]), .o_valid_state(v[5]));

  assign dc[0] = {28'b0, c0};
  assign dc[1] = {28'b0, c1};
  assign dc[2] = {30'b0, c2};
  assign dc[3] = {30'b0, c3};
  assign dc[4] = c4;
  assign dc[5] = c5;

  typedef struct {logic [31:0] q; logic w; logic v;} exp_t;
  exp_t        sb[$];
  int          wid[6] = '{4, 4, 2, 2, 32, 32};
  int          md[6]  = '{0, 1, 0, 1, 0, 1};
  logic [31:0] mq[6];
  logic        mw[6];
  int          errors = 0, checks = 0;

  function automatic logic [31:0] m_mask(int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic logic [31:0] m_seed(int m);
    return (m == 1) ? 32'h0 : 32'h1;
  endfunction

  function automatic logic m_valid(int n, int m, logic [31:0] q);
    int t = 0;
    if (m == 0) return $countones(q & m_mask(n)) == 1;
    for (int b = 1; b < n; b++) if (q[b] != q[b-1]) t++;
    return t <= 1;
  endfunction

  function automatic logic [31:0] m_next(int n, int m, logic [31:0] q, logic d);
    logic [31:0] r = '0;
    for (int b = 0; b < n; b++) begin
      if (!d) r[b] = (b == 0)   ? ((m == 1) ? ~q[n-1] : q[n-1]) : q[b-1];
      else    r[b] = (b == n-1) ? ((m == 1) ? ~q[0]   : q[0])   : q[b+1];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_q%0d", tag, i), dc[i], m_seed(md[i]));
      chk($sformatf("%s_w%0d", tag, i), {31'b0, w[i]}, 32'h0);
      chk($sformatf("%s_v%0d", tag, i), {31'b0, v[i]}, 32'h1);
      mq[i] = m_seed(md[i]);
      mw[i] = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic d, input logic l, input logic [31:0] val);
    exp_t x;
    logic ok;
    en = e; dir = d; ld = l; lv = val;
    for (int i = 0; i < 6; i++) begin
      ok = m_valid(wid[i], md[i], mq[i]);
      if (l) begin
        mq[i] = val & m_mask(wid[i]);
        mw[i] = 1'b0;
      end else if (e) begin
`ifdef PARAM_RC_SELF_CORRECT_EN
        if (!ok) begin
          mq[i] = m_seed(md[i]);
          mw[i] = 1'b0;
        end else begin
          mq[i] = m_next(wid[i], md[i], mq[i], d);
          mw[i] = mq[i] == m_seed(md[i]);
        end
`else
        mq[i] = m_next(wid[i], md[i], mq[i], d);
        mw[i] = mq[i] == m_seed(md[i]);
`endif
      end else mw[i] = 1'b0;
      sb.push_back('{mq[i], mw[i], m_valid(wid[i], md[i], mq[i])});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      x = sb.pop_front();
      chk($sformatf("sb_q%0d", i), dc[i], x.q);
      chk($sformatf("sb_w%0d", i), {31'b0, w[i]}, {31'b0, x.w});
      chk($sformatf("sb_v%0d", i), {31'b0, v[i]}, {31'b0, x.v});
    end
  endtask

  logic [3:0] r4_seq[8] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] j4_seq[8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [7:0] r4_wrap = 8'b1000_1000;
  logic [7:0] j4_wrap = 8'b1000_0000;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("rst_hold");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("r4_seq%0d", i), {28'b0, c0}, {28'b0, r4_seq[i]});
      chk($sformatf("r4_wrap%0d", i), {31'b0, w[0]}, {31'b0, r4_wrap[i]});
      chk($sformatf("j4_seq%0d", i), {28'b0, c1}, {28'b0, j4_seq[i]});
      chk($sformatf("j4_wrap%0d", i), {31'b0, w[1]}, {31'b0, j4_wrap[i]});
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("r4_at_0100", {28'b0, c0}, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("r4_rev1", {28'b0, c0}, 32'h2);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("r4_rev2", {28'b0, c0}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("r4_hold", {28'b0, c0}, 32'h1);
      chk("r4_hold_wrap", {31'b0, w[0]}, 32'h0);
    end
    step(1'b1, 1'b0, 1'b1, 32'h6);
    chk("r4_load", {28'b0, c0}, 32'h6);
    chk("r4_load_wrap", {31'b0, w[0]}, 32'h0);
    chk("r4_load_valid", {31'b0, v[0]}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PARAM_RC_SELF_CORRECT_EN
    chk("r4_after_illegal", {28'b0, c0}, 32'h1);
    chk("r4_after_illegal_wrap", {31'b0, w[0]}, 32'h0);
`else
    chk("r4_after_illegal", {28'b0, c0}, 32'hC);
`endif
    step(1'b0, 1'b0, 1'b1, 32'h8);
    chk("r4_load_1000", {28'b0, c0}, 32'h8);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("r4_resume", {28'b0, c0}, 32'h2);
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
